// File: rtl/uart_cmd_parser.sv
// ASCII hex command parser bridging the UART FIFOs and the register bus.
// Accepts W<addr><data><eol> / R<addr><eol> and answers K, read data or E.
module uart_cmd_parser #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           r_data,
    input  logic                 rx_empty,
    output logic                 rd_uart,
    output logic [7:0]           w_data,
    output logic                 wr_uart,
    input  logic                 tx_full,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [DATA_BITS-1:0] reg_wdata,
    output logic                 reg_we,
    output logic                 reg_re,
    input  logic [DATA_BITS-1:0] reg_rdata
);

    localparam int unsigned NA      = ADDR_BITS / 4;
    localparam int unsigned ND      = DATA_BITS / 4;
    localparam int unsigned BUF_LEN = (ND + 2 > 3) ? ND + 2 : 3;
    localparam int unsigned MAX_DIG = (NA > ND) ? NA : ND;
    localparam int unsigned CNT_W   = $clog2(MAX_DIG + 1);
    localparam int unsigned TXC_W   = $clog2(BUF_LEN + 1);

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_E  = 8'h45;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StEol,
        StDiscard,
        StExec,
        StRdWait,
        StTx
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   is_wr_q, is_wr_d;
    logic                   we_q, we_d;
    logic                   re_q, re_d;
    logic [BUF_LEN*8-1:0]   buf_q, buf_d;
    logic [TXC_W-1:0]       tx_cnt_q, tx_cnt_d;

    logic       is_term;
    logic       is_hex;
    logic       is_wcmd;
    logic       is_rcmd;
    logic [3:0] nib;

    // {valid, nibble}; letters map via low nibble + 9 ('A' = 0x41, 'a' = 0x61)
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            return {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            return {1'b1, c[3:0] + 4'd9};
        end
        return 5'b0;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        is_term = (r_data == ASCII_CR) || (r_data == ASCII_LF);
        is_wcmd = (r_data == 8'h57) || (r_data == 8'h77);
        is_rcmd = (r_data == 8'h52) || (r_data == 8'h72);
        {is_hex, nib} = hex_decode(r_data);
    end

    always_comb begin
        rd_uart = 1'b0;
        if (reset && !rx_empty) begin
            unique case (state_q)
                StIdle, StAddr, StData, StEol, StDiscard: rd_uart = 1'b1;
                default:                                  rd_uart = 1'b0;
            endcase
        end
        wr_uart = reset && (state_q == StTx) && !tx_full;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        buf_d    = buf_q;
        tx_cnt_d = tx_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (rd_uart) begin
                    if (is_wcmd || is_rcmd) begin
                        is_wr_d = is_wcmd;
                        cnt_d   = '0;
                        state_d = StAddr;
                    end else if (!is_term) begin
                        state_d = StDiscard;
                    end
                end
            end
            StAddr: begin
                if (rd_uart) begin
                    if (is_hex) begin
                        addr_d = (addr_q << 4) | ADDR_BITS'(nib);
                        if (cnt_q == CNT_W'(NA - 1)) begin
                            cnt_d   = '0;
                            state_d = is_wr_q ? StData : StEol;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (is_term) begin
                        buf_d          = '0;
                        buf_d[23:0]    = {ASCII_LF, ASCII_CR, ASCII_E};
                        tx_cnt_d       = TXC_W'(3);
                        state_d        = StTx;
                    end else begin
                        state_d = StDiscard;
                    end
                end
            end
            StData: begin
                if (rd_uart) begin
                    if (is_hex) begin
                        wdata_d = (wdata_q << 4) | DATA_BITS'(nib);
                        if (cnt_q == CNT_W'(ND - 1)) begin
                            cnt_d   = '0;
                            state_d = StEol;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (is_term) begin
                        buf_d       = '0;
                        buf_d[23:0] = {ASCII_LF, ASCII_CR, ASCII_E};
                        tx_cnt_d    = TXC_W'(3);
                        state_d     = StTx;
                    end else begin
                        state_d = StDiscard;
                    end
                end
            end
            StEol: begin
                if (rd_uart) begin
                    if (is_term) begin
                        we_d    = is_wr_q;
                        re_d    = !is_wr_q;
                        state_d = StExec;
                    end else begin
                        state_d = StDiscard;
                    end
                end
            end
            StDiscard: begin
                if (rd_uart && is_term) begin
                    buf_d       = '0;
                    buf_d[23:0] = {ASCII_LF, ASCII_CR, ASCII_E};
                    tx_cnt_d    = TXC_W'(3);
                    state_d     = StTx;
                end
            end
            StExec: begin
                if (is_wr_q) begin
                    buf_d       = '0;
                    buf_d[23:0] = {ASCII_LF, ASCII_CR, ASCII_K};
                    tx_cnt_d    = TXC_W'(3);
                    state_d     = StTx;
                end else begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                // reg_rdata is valid here, one cycle after the read strobe
                buf_d = '0;
                for (int i = 0; i < int'(ND); i++) begin
                    buf_d[8*i +: 8] = hex_ascii(reg_rdata[DATA_BITS-4-4*i +: 4]);
                end
                buf_d[8*ND +: 16] = {ASCII_LF, ASCII_CR};
                tx_cnt_d          = TXC_W'(ND + 2);
                state_d           = StTx;
            end
            StTx: begin
                if (wr_uart) begin
                    buf_d    = buf_q >> 8;
                    tx_cnt_d = tx_cnt_q - 1'b1;
                    if (tx_cnt_q == TXC_W'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            is_wr_q  <= 1'b0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            buf_q    <= '0;
            tx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            is_wr_q  <= is_wr_d;
            we_q     <= we_d;
            re_q     <= re_d;
            buf_q    <= buf_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign w_data    = buf_q[7:0];

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

ASCII command parser sitting between the UART core and the on-board register bus. It pops received bytes from the UART RX FIFO and decodes hex read/write commands. It issues single-cycle register bus accesses and pushes the ASCII replies into the UART TX FIFO. It gives host-side debug access to the VGA capture registers over the serial link.

## Interface
Parameters:
- ADDR_BITS, 8, register address width; must be a multiple of 4; NA = ADDR_BITS/4 hex digits.
- DATA_BITS, 8, register data width; must be a multiple of 4; ND = DATA_BITS/4 hex digits.

Ports:
- clk  in  1  system clock; same clock as the UART core.
- reset  in  1  synchronous, active-low reset (0 = reset).
- r_data  in  8  head byte of the UART RX FIFO.
- rx_empty  in  1  UART RX FIFO empty.
- rd_uart  out  1  pop the RX FIFO; 1-cycle pulse per byte.
- w_data  out  8  byte to the UART TX FIFO.
- wr_uart  out  1  push w_data into the TX FIFO.
- tx_full  in  1  UART TX FIFO full.
- reg_addr  out  ADDR_BITS  register bus address.
- reg_wdata  out  DATA_BITS  register bus write data.
- reg_we  out  1  write strobe; 1 cycle.
- reg_re  out  1  read strobe; 1 cycle.
- reg_rdata  in  DATA_BITS  read data; valid exactly 1 cycle after reg_re.

## Operation
- Commands:
  - Write: 'W'/'w', NA hex digits of address, ND hex digits of data, terminator.
  - Read: 'R'/'r', NA hex digits of address, terminator.
  - Terminator is CR (0x0D) or LF (0x0A). Hex digits are case-insensitive. No spaces are allowed.
- Replies, always terminated by CR LF:
  - Write: "K\r\n" (0x4B 0x0D 0x0A).
  - Read: ND uppercase hex digits, most significant digit first, then "\r\n".
  - Error: "E\r\n" (0x45 0x0D 0x0A).
- States:
  - IDLE: a command letter goes to ADDR. CR/LF is consumed silently, so empty lines and CRLF pairs produce no reply. Any other byte goes to DISCARD.
  - ADDR: shift hex digits into the address (left shift by 4, OR in the nibble). After NA digits go to DATA (write) or EOL (read). A terminator before NA digits sends an error reply. A non-hex byte goes to DISCARD.
  - DATA: same handling for ND digits, then go to EOL.
  - EOL: a terminator goes to EXEC. Any other byte, including an extra hex digit, goes to DISCARD.
  - DISCARD: consume bytes until a terminator, then send an error reply.
  - EXEC: drive reg_we (write) or reg_re (read) for one cycle. A write then loads the "K" reply into TX; a read goes to RDWAIT.
  - RDWAIT: capture reg_rdata, convert it to ASCII, load the reply into TX.
  - TX: shift reply bytes out of a buffer of max(3, ND+2) bytes, then return to IDLE.
- Popping: rd_uart = 1 only when rx_empty = 0 and state is IDLE, ADDR, DATA, EOL or DISCARD. The byte on r_data is processed in that same cycle. One byte can be consumed per cycle, back-to-back.
- No RX bytes are popped in EXEC, RDWAIT or TX; they wait in the RX FIFO.
- Pushing: wr_uart = 1 only when state is TX and tx_full = 0. w_data is the current buffer byte. The buffer advances only on push.
- rd_uart and wr_uart are combinational from state and the FIFO flags. All other outputs are registered.
- reg_addr and reg_wdata hold their last command's values until the next command's digits shift in.

## Timing
- Reset (reset = 0 at an edge):
  - State goes to IDLE and all shift registers clear.
  - reg_addr = 0, reg_wdata = 0, reg_we = 0, reg_re = 0, w_data = 0.
  - rd_uart = 0 and wr_uart = 0 while reset is low.
- Reset mid-command or mid-reply abandons it: no register strobe and no remaining reply bytes. Bytes still in the FIFOs are not touched.
- Reply latency, with terminator popped in cycle N and tx_full = 0:
  - Write: reg_we in N+1; first wr_uart in N+2; last byte in N+4.
  - Read: reg_re in N+1; reg_rdata sampled at the end of N+2; first wr_uart in N+3.
  - Error: first wr_uart in N+1; no register strobe.
- While tx_full = 1, TX stalls with no byte lost or duplicated; pushes resume on the first cycle tx_full = 0.

## Test plan
- Write: RX "W3A5C\r", tx_full = 0 -> one reg_we pulse with reg_addr = 0x3A, reg_wdata = 0x5C; TX bytes 4B 0D 0A.
- Read: RX "r3a\n" with reg_rdata = 0xB7 one cycle after reg_re -> reg_re once with reg_addr = 0x3A; TX 42 37 0D 0A ("B7\r\n").
- CRLF and errors: RX "W12\r\n" -> TX "E\r\n" only, and the trailing LF is ignored. RX "W1G34\r" -> "E\r\n", no reg_we. RX "R123\r" -> "E\r\n".
- Back-pressure: hold tx_full = 1 for 10 cycles during a read reply -> wr_uart stays 0; afterwards exactly 4 bytes arrive in order. No rd_uart occurs until the reply completes.
- Back-to-back: preload "W0011\rW0122\rR01\r" in the RX FIFO -> two writes, one read, replies "K\r\n" "K\r\n" "<rdata>\r\n" in order; rd_uart is never asserted while rx_empty = 1.
- Reset mid-op: assert reset after "W12" -> all outputs 0. Then RX "R00\r" -> normal read reply; the stale partial command has no effect.
